// File: rtl/shift_reg_univ.sv
// Universal shift register: parallel load plus multi-position fill/arithmetic/rotate
// shifts under a start/busy/done handshake. Define SHIFT_REG_UNIV_OVF_EN for the ovf flag.
module shift_reg_univ #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] IN,
    input  logic             load,
    input  logic             start,
    input  logic             dr,
    input  logic [1:0]       kind,
    input  logic             sin,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] o,
    output logic             msb,
    output logic             lsb,
    output logic             shout,
    output logic             ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    localparam logic [1:0] K_FILL  = 2'b00;
    localparam logic [1:0] K_ARITH = 2'b01;
    localparam logic [1:0] K_ROT   = 2'b10;

    // Operation parameters captured when start is accepted
    typedef struct packed {
        logic       dr;
        logic [1:0] kind;
        logic       sin;
    } op_t;

    state_t           state, state_nxt;
    op_t              op;
    logic [WIDTH-1:0] o_r;
    logic [WIDTH-1:0] shifted;
    logic [AMT_W-1:0] cnt;
    logic             shout_r;
    logic             fill_bit;
    logic             out_bit;
    logic             accept_load;
    logic             accept_start;

    assign accept_load  = (state == S_IDLE) && load;
    assign accept_start = (state == S_IDLE) && start && !load;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept_start) state_nxt = (amt == '0) ? S_DONE : S_SHIFT;
            S_SHIFT: if (cnt == AMT_W'(1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // One-position shift of the current contents according to the latched op
    always_comb begin
        fill_bit = 1'b0;
        out_bit  = 1'b0;
        shifted  = o_r;
        if (op.dr) begin
            out_bit = o_r[WIDTH-1];
            case (op.kind)
                K_FILL:  fill_bit = op.sin;
                K_ROT:   fill_bit = o_r[WIDTH-1];
                default: fill_bit = 1'b0;
            endcase
            shifted = {o_r[WIDTH-2:0], fill_bit};
        end else begin
            out_bit = o_r[0];
            case (op.kind)
                K_FILL:  fill_bit = op.sin;
                K_ARITH: fill_bit = o_r[WIDTH-1];
                K_ROT:   fill_bit = o_r[0];
                default: fill_bit = 1'b0;
            endcase
            shifted = {fill_bit, o_r[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            o_r     <= '0;
            shout_r <= 1'b0;
            cnt     <= '0;
            op      <= '0;
        end else begin
            state <= state_nxt;
            if (accept_load) begin
                o_r     <= IN;
                shout_r <= 1'b0;
            end else if (accept_start) begin
                op.dr   <= dr;
                // kind 11 behaves as serial fill
                op.kind <= (kind == 2'b11) ? K_FILL : kind;
                op.sin  <= sin;
                cnt     <= amt;
            end else if (state == S_SHIFT) begin
                o_r     <= shifted;
                shout_r <= out_bit;
                cnt     <= cnt - AMT_W'(1);
            end
        end
    end

`ifdef SHIFT_REG_UNIV_OVF_EN
    logic ovf_r;

    // Sticky for the whole operation: any sign change during an arithmetic left sets it
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (accept_load || accept_start) begin
            ovf_r <= 1'b0;
        end else if (state == S_SHIFT && op.dr && op.kind == K_ARITH &&
                     (o_r[WIDTH-1] != o_r[WIDTH-2])) begin
            ovf_r <= 1'b1;
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

    assign busy  = (state == S_SHIFT);
    assign done  = (state == S_DONE);
    assign o     = o_r;
    assign msb   = o_r[WIDTH-1];
    assign lsb   = o_r[0];
    assign shout = shout_r;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed table-driven bench for shift_reg_univ (WIDTH=8), plus hand sequences for
// multi-cycle corners: start during SHIFT, amt > WIDTH, reset mid-operation.
module tb_shift_reg_univ;

`ifdef SHIFT_REG_UNIV_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, load, start, dr, sin;
    logic [1:0] kind;
    logic [3:0] amt;
    logic [7:0] din;
    logic       busy, done, msb, lsb, shout, ovf;
    logic [7:0] o;

    int n_chk  = 0;
    int n_fail = 0;

    shift_reg_univ #(.WIDTH(8), .AMT_W(4)) dut (
        .clk(clk), .rst(rst), .IN(din), .load(load), .start(start), .dr(dr),
        .kind(kind), .sin(sin), .amt(amt), .busy(busy), .done(done), .o(o),
        .msb(msb), .lsb(lsb), .shout(shout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r, l, s, d;
        logic [1:0] k;
        logic       si;
        logic [3:0] a;
        logic [7:0] in;
        logic [7:0] eo;
        logic       eb, ed, esh, eov;
    } vec_t;

    vec_t vt[29];

    function automatic vec_t V(input logic r, l, s, d, input logic [1:0] k, input logic si,
                               input logic [3:0] a, input logic [7:0] in, eo,
                               input logic eb, ed, esh, eov);
        vec_t v;
        v.r = r; v.l = l; v.s = s; v.d = d; v.k = k; v.si = si; v.a = a; v.in = in;
        v.eo = eo; v.eb = eb; v.ed = ed; v.esh = esh; v.eov = eov;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic r, l, s, d, input logic [1:0] k, input logic si,
                       input logic [3:0] a, input logic [7:0] in);
        rst = r; load = l; start = s; dr = d; kind = k; sin = si; amt = a; din = in;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 2'b00, 0, 4'd0, 8'h00);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts busy samples (current one included) until done, bounded
    task automatic run_to_done(input string nm, output int nbusy);
        int guard;
        nbusy = 0;
        guard = 0;
        while (!done && guard < 40) begin
            if (busy) nbusy++;
            tick();
            guard++;
        end
        chk({nm, " done reached"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int nb;
        int dseen;

        vt[0]  = V(1,0,0,0,2'd0,0,4'd0,8'h00, 8'h00,0,0,0,0);
        vt[1]  = V(0,1,0,0,2'd0,0,4'd0,8'hCC, 8'hCC,0,0,0,0);
        vt[2]  = V(0,0,1,0,2'd1,0,4'd3,8'h00, 8'hCC,1,0,0,0);
        vt[3]  = V(0,0,0,0,2'd0,0,4'd0,8'h00, 8'hE6,1,0,0,0);
        vt[4]  = V(0,0,0,0,2'd0,0,4'd0,8'h00, 8'hF3,1,0,0,0);
        vt[5]  = V(0,0,0,0,2'd0,0,4'd0,8'h00, 8'hF9,0,1,1,0);
        vt[6]  = V(0,0,0,0,2'd0,0,4'd0,8'h00, 8'hF9,0,0,1,0);
        vt[7]  = V(0,1,0,0,2'd0,0,4'd0,8'h96, 8'h96,0,0,0,0);
        vt[8]  = V(0,0,1,1,2'd2,0,4'd3,8'h00, 8'h96,1,0,0,0);
        vt[9]  = V(0,0,0,0,2'd0,0,4'd0,8'h00, 8'h2D,1,0,1,0);
        vt[10] = V(0,0,0,0,2'd0,0,4'd0,8'h00, 8'h5A,1,0,0,0);
        vt[11] = V(0,0,0,0,2'd0,0,4'd0,8'h00, 8'hB4,0,1,0,0);
        vt[12] = V(0,0,1,0,2'd0,1,4'd5,8'h00, 8'hB4,0,0,0,0);  // start in DONE ignored
        vt[13] = V(0,0,1,0,2'd0,1,4'd2,8'h00, 8'hB4,1,0,0,0);
        vt[14] = V(0,0,0,0,2'd0,0,4'd0,8'h00, 8'hDA,1,0,0,0);
        vt[15] = V(0,0,0,0,2'd0,0,4'd0,8'h00, 8'hED,0,1,0,0);
        vt[16] = V(0,0,0,0,2'd0,0,4'd0,8'h00, 8'hED,0,0,0,0);
        vt[17] = V(0,1,0,0,2'd0,0,4'd0,8'h40, 8'h40,0,0,0,0);
        vt[18] = V(0,0,1,1,2'd1,0,4'd1,8'h00, 8'h40,1,0,0,0);
        vt[19] = V(0,0,0,0,2'd0,0,4'd0,8'h00, 8'h80,0,1,0,OVF_ON);
        vt[20] = V(0,0,0,0,2'd0,0,4'd0,8'h00, 8'h80,0,0,0,OVF_ON);
        vt[21] = V(0,1,1,0,2'd2,0,4'd3,8'h5A, 8'h5A,0,0,0,0);  // load beats start
        vt[22] = V(0,0,0,0,2'd0,0,4'd0,8'h00, 8'h5A,0,0,0,0);
        vt[23] = V(0,0,1,1,2'd0,1,4'd0,8'h00, 8'h5A,0,1,0,0);  // amt=0
        vt[24] = V(0,0,0,0,2'd0,0,4'd0,8'h00, 8'h5A,0,0,0,0);
        vt[25] = V(0,0,1,1,2'd3,1,4'd2,8'h00, 8'h5A,1,0,0,0);  // kind 11 = fill
        vt[26] = V(0,0,0,0,2'd0,0,4'd0,8'h00, 8'hB5,1,0,0,0);
        vt[27] = V(0,0,0,0,2'd0,0,4'd0,8'h00, 8'h6B,0,1,1,0);
        vt[28] = V(0,0,0,0,2'd0,0,4'd0,8'h00, 8'h6B,0,0,1,0);

        idle();
        rst = 1'b1;
        #2;
        for (int i = 0; i < 29; i++) begin
            drv(vt[i].r, vt[i].l, vt[i].s, vt[i].d, vt[i].k, vt[i].si, vt[i].a, vt[i].in);
            tick();
            chk($sformatf("row%0d o", i), {24'd0, o}, {24'd0, vt[i].eo});
            chk($sformatf("row%0d busy", i), {31'd0, busy}, {31'd0, vt[i].eb});
            chk($sformatf("row%0d done", i), {31'd0, done}, {31'd0, vt[i].ed});
            chk($sformatf("row%0d shout", i), {31'd0, shout}, {31'd0, vt[i].esh});
            chk($sformatf("row%0d ovf", i), {31'd0, ovf}, {31'd0, vt[i].eov});
            chk($sformatf("row%0d msb/lsb", i), {30'd0, msb, lsb},
                {30'd0, vt[i].eo[7], vt[i].eo[0]});
        end

        // Rotate right by 9 from 6B wraps to a rotate by 1
        drv(0, 0, 1, 0, 2'd2, 0, 4'd9, 8'h00);
        tick();
        idle();
        run_to_done("rot9", nb);
        chk("rot9 busy cycles", nb, 32'd9);
        chk("rot9 o", {24'd0, o}, 32'h0000_00B5);
        chk("rot9 shout", {31'd0, shout}, 32'd1);
        tick();

        // Start held during SHIFT and DONE must not alter or restart the operation
        drv(0, 1, 0, 0, 2'd0, 0, 4'd0, 8'h81);
        tick();
        drv(0, 0, 1, 0, 2'd0, 0, 4'd4, 8'h00);
        tick();
        drv(0, 0, 1, 1, 2'd2, 1, 4'd15, 8'h00);
        run_to_done("midstart", nb);
        chk("midstart busy cycles", nb, 32'd4);
        chk("midstart o", {24'd0, o}, 32'h0000_0008);
        chk("midstart shout", {31'd0, shout}, 32'd0);
        tick();
        idle();
        chk("midstart no restart", {31'd0, busy}, 32'd0);
        tick();

        // Reset after E3 aborts with no done pulse; a later load works
        drv(0, 1, 0, 0, 2'd0, 0, 4'd0, 8'hFF);
        tick();
        drv(0, 0, 1, 0, 2'd0, 0, 4'd7, 8'h00);
        tick();
        idle();
        dseen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) dseen++;
        end
        chk("abort pre-reset o", {24'd0, o}, 32'h0000_001F);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort o", {24'd0, o}, 32'd0);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort shout", {31'd0, shout}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (done || busy) dseen++;
            tick();
        end
        chk("abort no done", dseen, 32'd0);
        drv(0, 1, 0, 0, 2'd0, 0, 4'd0, 8'h33);
        tick();
        idle();
        chk("post-abort load o", {24'd0, o}, 32'h0000_0033);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
